// File: rtl/adc_channel_averager.sv
// -----------------------------------------------------------------------------
// adc_channel_averager
//
// Scans NUM_CH ADC result registers round-robin. Each round reads every cell
// once. After 2^AVG_LOG2 rounds it presents one averaged 12-bit sample per
// channel on a valid/ready stream. Between rounds it idles for SCAN_DIV cycles.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_reset        asynchronous active-high reset
//   i_enable       run enable; low aborts to IDLE on the next edge
//   o_raddr        registered read address to the ADC result registers
//   i_rdata        read data, valid one cycle after o_raddr (only [11:0] used)
//   o_out_valid    averaged sample available
//   i_out_ready    consumer accepts the sample when high with o_out_valid
//   o_out_channel  cell index of o_out_data (0 when not valid)
//   o_out_data     averaged sample (0 when not valid)
//   o_round_done   one-cycle pulse after the last cell of a round is captured
// -----------------------------------------------------------------------------
module adc_channel_averager #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 7,
    parameter int BASE_ADDR  = 1,
    parameter int AVG_LOG2   = 2,
    parameter int SCAN_DIV   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [31:0]           i_rdata,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [2:0]            o_out_channel,
    output logic [11:0]           o_out_data,
    output logic                  o_round_done
);

    localparam int ACC_W = 12 + AVG_LOG2;
    // Keep the round counter at least one bit wide so AVG_LOG2=0 still builds.
    localparam int RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CNT_W = $clog2(SCAN_DIV + 1);

    localparam logic [2:0]       LAST_CH  = 3'(NUM_CH - 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_ch;
    logic [2:0]            w_ch_next;
    logic [RND_W-1:0]      r_round;
    logic [RND_W-1:0]      w_round_next;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [CNT_W-1:0]      w_wait_next;
    logic                  r_round_done;
    logic                  w_round_done_next;
    logic                  w_acc_we;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ACC_W-1:0]      r_acc [NUM_CH];
    logic [11:0]           w_sample;
    logic                  w_unused_rdata_hi;

    assign w_sample          = i_rdata[11:0];
    assign w_unused_rdata_hi = ^i_rdata[31:12];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_ch_next         = r_ch;
        w_round_next      = r_round;
        w_wait_next       = r_wait_cnt;
        w_round_done_next = 1'b0;
        w_acc_we          = 1'b0;

        if (r_state != S_IDLE && !i_enable) begin
            // Abort: partial sums are left in place but the restart begins at
            // round 0, which overwrites rather than accumulates.
            w_state_next = S_IDLE;
            w_ch_next    = 3'd0;
            w_round_next = '0;
            w_wait_next  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        w_state_next = S_ADDR;
                        w_ch_next    = 3'd0;
                        w_round_next = '0;
                    end
                end
                S_ADDR: begin
                    w_state_next = S_CAPT;
                end
                S_CAPT: begin
                    w_acc_we = 1'b1;
                    if (r_ch == LAST_CH) begin
                        w_round_done_next = 1'b1;
                        if (r_round == LAST_RND) begin
                            w_state_next = S_EMIT;
                            w_ch_next    = 3'd0;
                        end else begin
                            w_round_next = r_round + 1'b1;
                            w_state_next = S_WAIT;
                            w_wait_next  = '0;
                        end
                    end else begin
                        w_ch_next    = r_ch + 3'd1;
                        w_state_next = S_ADDR;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == LAST_CNT) begin
                        w_state_next = S_ADDR;
                        w_ch_next    = 3'd0;
                        w_wait_next  = '0;
                    end else begin
                        w_wait_next = r_wait_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (i_out_ready) begin
                        if (r_ch == LAST_CH) begin
                            w_round_next = '0;
                            w_ch_next    = 3'd0;
                            w_wait_next  = '0;
                            w_state_next = S_WAIT;
                        end else begin
                            w_ch_next = r_ch + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_ch         <= 3'd0;
            r_round      <= '0;
            r_wait_cnt   <= '0;
            r_round_done <= 1'b0;
            r_raddr      <= ADDR_WIDTH'(BASE_ADDR);
        end else begin
            r_state      <= w_state_next;
            r_ch         <= w_ch_next;
            r_round      <= w_round_next;
            r_wait_cnt   <= w_wait_next;
            r_round_done <= w_round_done_next;
            // Address is loaded on entry to ADDR so that the registered read
            // data lands during CAPT.
            if (w_state_next == S_ADDR) begin
                r_raddr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(w_ch_next);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel accumulators; round 0 loads, later rounds add.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_acc
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_acc[gi] <= '0;
                end else if (w_acc_we && r_ch == 3'(gi)) begin
                    if (r_round == '0) begin
                        r_acc[gi] <= ACC_W'(w_sample);
                    end else begin
                        r_acc[gi] <= r_acc[gi] + ACC_W'(w_sample);
                    end
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_raddr       = r_raddr;
    assign o_round_done  = r_round_done;
    assign o_out_valid   = (r_state == S_EMIT);
    assign o_out_channel = o_out_valid ? r_ch : 3'd0;
    assign o_out_data    = o_out_valid ? r_acc[r_ch][AVG_LOG2 +: 12] : 12'd0;

endmodule

// File: doc/adc_channel_averager.md
ADC_CHANNEL_AVERAGER -- requirements
Module: adc_channel_averager

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, width of the result-register read address.
REQ-002 SHALL have parameter NUM_CH, default 7, number of ADC cells scanned (1..8).
REQ-003 SHALL have parameter BASE_ADDR, default 1, read address of cell 0; cell k is at BASE_ADDR+k.
REQ-004 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per channel (0..4).
REQ-005 SHALL have parameter SCAN_DIV, default 16, idle cycles between scan rounds (>=1).
REQ-006 SHALL have port CLK input 1 system clock; all logic on rising edge.
REQ-007 SHALL have port RESET input 1, asynchronous, active-high reset.
REQ-008 SHALL have port ENABLE input 1, run enable; low is a synchronous abort to IDLE.
REQ-009 SHALL have port RADDR output ADDR_WIDTH, read address to the ADC core result registers.
REQ-010 SHALL have port RDATA input 32, read data; it is valid one cycle after RADDR and only [11:0] is used.
REQ-011 SHALL have port OUT_VALID output 1, averaged sample available.
REQ-012 SHALL have port OUT_READY input 1, consumer accepts the sample when it is high together with OUT_VALID.
REQ-013 SHALL have port OUT_CHANNEL output 3, cell index of OUT_DATA.
REQ-014 SHALL have port OUT_DATA output 12, averaged 12-bit sample.
REQ-015 SHALL have port ROUND_DONE output 1, one-cycle pulse at the end of each scan round.

Function
REQ-016 SHALL implement states IDLE, ADDR, CAPT, WAIT, EMIT, all in one registered state variable.
REQ-017 IDLE: SHALL go to ADDR with ch=0 and round=0 on the next edge when ENABLE=1.
REQ-018 ADDR: SHALL drive RADDR=BASE_ADDR+ch (registered) and go to CAPT.
REQ-019 CAPT: SHALL capture RDATA[11:0]; acc[ch] SHALL be loaded with the sample when round=0, otherwise acc[ch]+sample is stored.
REQ-020 Each acc SHALL be 12+AVG_LOG2 bits wide and SHALL never overflow.
REQ-021 CAPT with ch<NUM_CH-1: ch SHALL increment and the state SHALL go to ADDR, giving one round of 2*NUM_CH cycles.
REQ-022 CAPT with ch=NUM_CH-1: ROUND_DONE SHALL pulse for one cycle.
REQ-023 At that point, if round=2^AVG_LOG2-1, the state SHALL go to EMIT with ch=0; otherwise round SHALL increment and the state SHALL go to WAIT.
REQ-024 WAIT: SHALL count SCAN_DIV cycles, then go to ADDR with ch=0.
REQ-025 EMIT: OUT_VALID=1, OUT_CHANNEL=ch, and OUT_DATA=acc[ch]>>AVG_LOG2 (truncating, no rounding).
REQ-026 EMIT outputs SHALL be held stable while OUT_READY=0.
REQ-027 An EMIT handshake on the last channel SHALL clear round and go to WAIT; any other handshake SHALL increment ch and stay in EMIT, allowing back-to-back outputs.
REQ-028 OUT_VALID SHALL be 0 in every state except EMIT.
REQ-029 OUT_CHANNEL and OUT_DATA SHALL be 0 whenever OUT_VALID=0.
REQ-030 ENABLE=0 in any non-IDLE state SHALL go to IDLE on the next edge; OUT_VALID drops (the only allowed withdrawal), round and ch clear, and partial sums are discarded.
REQ-031 With AVG_LOG2=0, every round SHALL emit samples unmodified.
REQ-032 RDATA[31:12] SHALL be ignored.

Reset
REQ-033 While RESET is high: state=IDLE, ch=0, round=0, WAIT counter=0, all acc=0, RADDR=BASE_ADDR, OUT_VALID=0, OUT_CHANNEL=0, OUT_DATA=0, ROUND_DONE=0.
REQ-034 A RESET assertion mid-round or mid-EMIT SHALL take effect immediately, without waiting for a clock edge.
REQ-035 After RESET deasserts, the first transition SHALL happen at the first rising CLK edge.

Verification (NUM_CH=7, BASE_ADDR=1, AVG_LOG2=2, SCAN_DIV=4, RDATA returned one cycle after RADDR)
REQ-036 Assert RESET asynchronously mid-CAPT -> all outputs reach their REQ-033 values before the next edge; RADDR=1.
REQ-037 Address k+1 returns 100*k, OUT_READY=1 -> after 4 rounds the bench sees 7 consecutive handshakes: ch0..6 with data 0,100,...,600; ROUND_DONE pulses 4 times.
REQ-038 Cell 0 returns 1,2,3,5 over the 4 rounds -> OUT_DATA=2 (11>>2) on ch0.
REQ-039 OUT_READY=0 for 10 cycles while ch2 is presented -> OUT_VALID, OUT_CHANNEL=2, and OUT_DATA stay unchanged; ch3 appears on the cycle after READY rises.
REQ-040 RDATA=0xFFFF_F800 on all cells -> every OUT_DATA=0x800.
REQ-041 ENABLE low during round 2, then high -> state is IDLE the next cycle; the restart captures round 0 fresh, so the output equals the average of the new samples only.
